mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 168 ++++++++++++++++
 tb/tb_mem_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the M stage and a req/ack data memory.
// One outstanding access at a time; the upstream pipeline is frozen via
// mem_stall until the memory answers or the TIMEOUT watchdog expires.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are
// trapped (misalign pulse, no bus request) instead of being force-aligned.
//
// state | meaning
// IDLE  | no access in flight; a request here launches one
// WAIT  | dm_req held high, waiting for dm_ack or timeout
// DONE  | one-cycle completion slot, stall released, no new access
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] M_alu_out,
    input  logic [31:0] M_rs2_data,
    input  logic [2:0]  M_funct3,
    input  logic        M_mem_read,
    input  logic        M_mem_write,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] ld_data,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  wait_cnt;
    logic        req, is_store, is_byte, is_half, misaligned_acc, trap, timeout;
    logic [1:0]  off;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n, load_val;
    logic [1:0]  off_q;
    logic        byte_q, half_q, uns_q, load_q;
    logic        misalign_q;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Decode the M-stage request: size, forced-alignment offset, strobes, lanes.
    always_comb begin
        req            = M_mem_read | M_mem_write;
        is_store       = M_mem_write;
        is_byte        = (M_funct3[1:0] == 2'b00);
        is_half        = (M_funct3[1:0] == 2'b01);
        misaligned_acc = (is_half & M_alu_out[0]) |
                         (!is_byte & !is_half & (M_alu_out[1:0] != 2'b00));
        off            = is_byte ? M_alu_out[1:0] :
                         is_half ? {M_alu_out[1], 1'b0} : 2'b00;
        wstrb_n        = !is_store ? 4'b0000 :
                         is_byte   ? (4'b0001 << off) :
                         is_half   ? (4'b0011 << off) : 4'b1111;
        wdata_n        = !is_store ? 32'h0 :
                         is_byte   ? {4{M_rs2_data[7:0]}} :
                         is_half   ? {2{M_rs2_data[15:0]}} : M_rs2_data;
`ifdef LSU_MISALIGN_TRAP_EN
        trap           = req & misaligned_acc;
`else
        trap           = 1'b0;
`endif
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        rd_byte  = dm_rdata[{off_q, 3'b000} +: 8];
        rd_half  = dm_rdata[{off_q[1], 4'b0000} +: 16];
        load_val = dm_rdata;
        if (byte_q)
            load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
        else if (half_q)
            load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
    end

    // Next-state and stall logic; stall is forced low while in reset.
    always_comb begin
        state_n   = state;
        mem_stall = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    state_n   = trap ? DONE : WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (dm_ack) begin
                    state_n = DONE;
                end else if (wait_cnt == TO_LAST) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (rst)
            mem_stall = 1'b0;
    end

    assign dm_req   = (state == WAIT);
    assign misalign = misalign_q;

    // State register, request capture, watchdog counter and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dm_we      <= 1'b0;
            dm_addr    <= 32'h0;
            dm_wstrb   <= 4'b0000;
            dm_wdata   <= 32'h0;
            ld_data    <= 32'h0;
            bus_err    <= 1'b0;
            misalign_q <= 1'b0;
            wait_cnt   <= 8'h0;
            off_q      <= 2'b00;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            uns_q      <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state      <= state_n;
            bus_err    <= timeout;
            misalign_q <= (state == IDLE) & trap;
            case (state)
                IDLE: begin
                    if (req && !trap) begin
                        dm_addr  <= {M_alu_out[31:2], 2'b00};
                        dm_we    <= is_store;
                        dm_wstrb <= wstrb_n;
                        dm_wdata <= wdata_n;
                        off_q    <= off;
                        byte_q   <= is_byte;
                        half_q   <= is_half;
                        uns_q    <= M_funct3[2];
                        load_q   <= !is_store;
                        wait_cnt <= 8'h0;
                    end else if (trap && !is_store) begin
                        ld_data  <= 32'h0;
                    end
                end
                WAIT: begin
                    if (dm_ack) begin
                        if (load_q)
                            ld_data <= load_val;
                    end else if (timeout) begin
                        ld_data <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed-vector bench for mem_lsu (TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] M_alu_out, M_rs2_data;
    logic [2:0]  M_funct3;
    logic        M_mem_read, M_mem_write;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] ld_data;
    logic        mem_stall, bus_err, misalign;

    int checks = 0;
    int errors = 0;

    mem_lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data), .M_funct3(M_funct3),
        .M_mem_read(M_mem_read), .M_mem_write(M_mem_write),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .ld_data(ld_data), .mem_stall(mem_stall),
        .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one access, answer it after n_noack WAIT cycles, return in DONE.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input int n_noack, input logic [31:0] rdata);
        @(negedge clk);
        M_mem_read = rd; M_mem_write = wr; M_funct3 = f3;
        M_alu_out = addr; M_rs2_data = rs2;
        #1;
        chk("stall_on_req", {31'h0, mem_stall}, 32'h1);
        chk("no_req_in_idle", {31'h0, dm_req}, 32'h0);
        @(negedge clk);
        M_mem_read = 1'b0; M_mem_write = 1'b0;
        for (int i = 0; i < n_noack; i++) begin
            chk("req_held", {31'h0, dm_req}, 32'h1);
            @(negedge clk);
        end
        chk("req_at_ack", {31'h0, dm_req}, 32'h1);
        chk("stall_at_ack", {31'h0, mem_stall}, 32'h1);
        dm_ack = 1'b1; dm_rdata = rdata;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("done_stall", {31'h0, mem_stall}, 32'h0);
        chk("done_req", {31'h0, dm_req}, 32'h0);
        chk("done_bus_err", {31'h0, bus_err}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        M_alu_out = 32'h0; M_rs2_data = 32'h0; M_funct3 = 3'b000;
        M_mem_read = 1'b0; M_mem_write = 1'b0;
        dm_ack = 1'b0; dm_rdata = 32'h0;

        // Reset: stall suppressed even with a request present.
        @(negedge clk);
        M_mem_read = 1'b1;
        #1 chk("stall_in_rst", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        M_mem_read = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
        chk("rst_dm_we", {31'h0, dm_we}, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wstrb", {28'h0, dm_wstrb}, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);

        // LW 0x100, ack in first WAIT cycle.
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        chk("lw_addr", dm_addr, 32'h100);
        chk("lw_wstrb", {28'h0, dm_wstrb}, 32'h0);
        chk("lw_we", {31'h0, dm_we}, 32'h0);
        chk("lw_data", ld_data, 32'hDEADBEEF);

        // LB / LBU from 0x103.
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
        chk("lb_addr", dm_addr, 32'h100);
        chk("lb_data", ld_data, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
        chk("lbu_data", ld_data, 32'h00000080);

        // LH / LHU from 0x102, and LB from byte 1.
        access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80112233);
        chk("lh_data", ld_data, 32'hFFFF8011);
        access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80112233);
        chk("lhu_data", ld_data, 32'h00008011);
        access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h80112233);
        chk("lb1_data", ld_data, 32'h00000022);

        // SH to 0x202.
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 0, 32'h0);
        chk("sh_addr", dm_addr, 32'h200);
        chk("sh_wstrb", {28'h0, dm_wstrb}, 32'hC);
        chk("sh_wdata", dm_wdata, 32'hABCDABCD);
        chk("sh_we", {31'h0, dm_we}, 32'h1);
        chk("sh_keeps_ld", ld_data, 32'h00000022);

        // SB to 0x101; read+write together counts as a store.
        access(1'b1, 1'b1, 3'b000, 32'h101, 32'h1234565A, 0, 32'hFFFFFFFF);
        chk("sb_wstrb", {28'h0, dm_wstrb}, 32'h2);
        chk("sb_wdata", dm_wdata, 32'h5A5A5A5A);
        chk("sb_we", {31'h0, dm_we}, 32'h1);
        chk("sb_keeps_ld", ld_data, 32'h00000022);

        // Reserved funct3 111 behaves as a word load.
        access(1'b1, 1'b0, 3'b111, 32'h404, 32'h0, 2, 32'h80112233);
        chk("rsv_addr", dm_addr, 32'h404);
        chk("rsv_data", ld_data, 32'h80112233);

        // Timeout: no ack for 16 WAIT cycles.
        @(negedge clk);
        M_mem_read = 1'b1; M_funct3 = 3'b010; M_alu_out = 32'h100;
        @(negedge clk);
        M_mem_read = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_req_held", {31'h0, dm_req}, 32'h1);
            chk("to_no_err_yet", {31'h0, bus_err}, 32'h0);
            @(negedge clk);
        end
        chk("to_bus_err", {31'h0, bus_err}, 32'h1);
        chk("to_ld_zero", ld_data, 32'h0);
        chk("to_stall_rel", {31'h0, mem_stall}, 32'h0);
        chk("to_req_drop", {31'h0, dm_req}, 32'h0);
        @(negedge clk);
        chk("to_err_pulse", {31'h0, bus_err}, 32'h0);

        // Ack in the 16th WAIT cycle wins over the timeout.
        access(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 15, 32'hCAFEF00D);
        chk("ackwin_data", ld_data, 32'hCAFEF00D);

        // Reset in 3rd WAIT cycle, late ack afterwards is ignored.
        @(negedge clk);
        M_mem_read = 1'b1; M_funct3 = 3'b010; M_alu_out = 32'h040;
        @(negedge clk);
        M_mem_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rstw_stall", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h12345678;
        #1;
        chk("rstw_req", {31'h0, dm_req}, 32'h0);
        chk("rstw_addr", dm_addr, 32'h0);
        @(negedge clk);
        dm_ack = 1'b0;
        chk("rstw_ld", ld_data, 32'h0);
        chk("rstw_req2", {31'h0, dm_req}, 32'h0);
        chk("rstw_stall2", {31'h0, mem_stall}, 32'h0);

        // SW to misaligned 0x301.
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        M_mem_write = 1'b1; M_funct3 = 3'b010; M_alu_out = 32'h301;
        M_rs2_data = 32'h11223344;
        #1 chk("mis_stall", {31'h0, mem_stall}, 32'h1);
        @(negedge clk);
        M_mem_write = 1'b0;
        chk("mis_pulse", {31'h0, misalign}, 32'h1);
        chk("mis_no_req", {31'h0, dm_req}, 32'h0);
        chk("mis_done_stall", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        chk("mis_pulse_end", {31'h0, misalign}, 32'h0);
        chk("mis_no_req2", {31'h0, dm_req}, 32'h0);
`else
        access(1'b0, 1'b1, 3'b010, 32'h301, 32'h11223344, 0, 32'h0);
        chk("sw_align_addr", dm_addr, 32'h300);
        chk("sw_align_wstrb", {28'h0, dm_wstrb}, 32'hF);
        chk("sw_align_wdata", dm_wdata, 32'h11223344);
        chk("sw_no_misalign", {31'h0, misalign}, 32'h0);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
